// File: rtl/decoder_ctrl_fsm_if.sv
// Instruction-field and control-output bundle between an instruction source and decoder_ctrl_fsm.
interface decoder_ctrl_fsm_if #(
   parameter int unsigned ALU_W = 3
);
   logic             instr_valid;
   logic [3:0]       rd;
   logic [1:0]       op;
   logic [5:0]       funct;
   logic [3:0]       m_bits;
   logic             m_busy;

   logic             pcs;
   logic             reg_w;
   logic             mem_w;
   logic             mem_to_reg;
   logic             alu_src;
   logic [1:0]       imm_src;
   logic [1:0]       reg_src;
   logic             no_write;
   logic [ALU_W-1:0] alu_control;
   logic [1:0]       flag_w;
   logic             m_start;
   logic [1:0]       m_cycle_op;
   logic             stall;
   logic             dec_valid;
   logic             undef;

   modport master (
      output instr_valid, rd, op, funct, m_bits, m_busy,
      input  pcs, reg_w, mem_w, mem_to_reg, alu_src, imm_src, reg_src, no_write,
             alu_control, flag_w, m_start, m_cycle_op, stall, dec_valid, undef
   );

   modport slave (
      input  instr_valid, rd, op, funct, m_bits, m_busy,
      output pcs, reg_w, mem_w, mem_to_reg, alu_src, imm_src, reg_src, no_write,
             alu_control, flag_w, m_start, m_cycle_op, stall, dec_valid, undef
   );
endinterface

// File: rtl/decoder_ctrl_fsm.sv
// Instruction decoder with a multi-cycle (MUL/DIV) sequencing FSM; all control outputs registered.
// DIV support is enabled by defining DECODER_CTRL_DIV_EN.
module decoder_ctrl_fsm #(
   parameter int unsigned ALU_W      = 3,
   parameter int unsigned MC_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   decoder_ctrl_fsm_if.slave bus_if
);
   localparam int unsigned      CNT_W    = $clog2(MC_TIMEOUT);
   localparam int unsigned      ALU_LIM  = 1 << ALU_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'd0;
   localparam logic [3:0] CMD_EOR = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_ADD = 4'd4;
   localparam logic [3:0] CMD_TST = 4'd8;
   localparam logic [3:0] CMD_CMP = 4'd10;
   localparam logic [3:0] CMD_CMN = 4'd11;
   localparam logic [3:0] CMD_ORR = 4'd12;

   typedef enum logic [1:0] {IDLE, MC_START, MC_WAIT, MC_DONE} state_e;

   typedef struct packed {
      logic             pcs;
      logic             reg_w;
      logic             mem_w;
      logic             mem_to_reg;
      logic             alu_src;
      logic [1:0]       imm_src;
      logic [1:0]       reg_src;
      logic             no_write;
      logic [ALU_W-1:0] alu_control;
      logic [1:0]       flag_w;
      logic             m_start;
      logic [1:0]       m_cycle_op;
      logic             stall;
      logic             dec_valid;
      logic             undef;
   } ctrl_t;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rd_q, rd_d;
   ctrl_t            ctrl_q, ctrl_d;

   ctrl_t      dec;
   logic       legal;
   logic       is_mc;
   logic [1:0] mc_op;
   logic [2:0] alu_code;
   logic [3:0] cmd;

   // Single-cycle decode of the presented instruction, including the undefined-instruction squash.
   always_comb begin
      dec      = '0;
      legal    = 1'b1;
      is_mc    = 1'b0;
      mc_op    = 2'b00;
      alu_code = 3'd0;
      cmd      = bus_if.funct[4:1];
      case (bus_if.op)
         OP_DP: begin
            if (!bus_if.funct[5] && bus_if.m_bits == 4'b1001) begin
               if (cmd == CMD_AND) begin
                  is_mc = 1'b1;
               end
`ifdef DECODER_CTRL_DIV_EN
               else if (cmd == CMD_EOR) begin
                  is_mc = 1'b1;
                  mc_op = 2'b01;
               end
`endif
               else begin
                  legal = 1'b0;
               end
            end else begin
               case (cmd)
                  CMD_ADD, CMD_CMN: alu_code = 3'd0;
                  CMD_SUB, CMD_CMP: alu_code = 3'd1;
                  CMD_AND, CMD_TST: alu_code = 3'd2;
                  CMD_ORR:          alu_code = 3'd3;
                  CMD_EOR:          alu_code = 3'd4;
                  default:          legal    = 1'b0;
               endcase
               dec.no_write = (cmd == CMD_CMP) || (cmd == CMD_CMN) || (cmd == CMD_TST);
               dec.reg_w    = !dec.no_write;
               dec.alu_src  = bus_if.funct[5];
               if (bus_if.funct[0]) begin
                  dec.flag_w = (alu_code <= 3'd1) ? 2'b11 : 2'b10;
               end
            end
         end
         OP_MEM: begin
            dec.alu_src = 1'b1;
            dec.imm_src = 2'b01;
            alu_code    = bus_if.funct[3] ? 3'd0 : 3'd1;
            if (bus_if.funct[0]) begin
               dec.reg_w      = 1'b1;
               dec.mem_to_reg = 1'b1;
            end else begin
               dec.mem_w   = 1'b1;
               dec.reg_src = 2'b10;
            end
         end
         OP_BR: begin
            dec.pcs     = 1'b1;
            dec.alu_src = 1'b1;
            dec.imm_src = 2'b10;
            dec.reg_src = 2'b01;
         end
         default: legal = 1'b0;
      endcase
      if (32'(alu_code) >= ALU_LIM) begin
         legal = 1'b0;
      end
      dec.alu_control = ALU_W'(alu_code);
      dec.pcs         = dec.pcs | ((bus_if.rd == 4'hF) && dec.reg_w);
      if (!legal) begin
         dec.undef  = 1'b1;
         dec.reg_w  = 1'b0;
         dec.mem_w  = 1'b0;
         dec.pcs    = 1'b0;
         dec.flag_w = 2'b00;
      end
      dec.dec_valid = 1'b1;
   end

   // Next state and next registered outputs; MC_DONE accepts a new instruction just like IDLE.
   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      rd_d                = rd_q;
      ctrl_d              = '0;
      ctrl_d.m_cycle_op   = ctrl_q.m_cycle_op;
      case (state_q)
         IDLE, MC_DONE: begin
            state_d = IDLE;
            if (bus_if.instr_valid) begin
               if (is_mc) begin
                  state_d           = MC_START;
                  rd_d              = bus_if.rd;
                  ctrl_d.m_start    = 1'b1;
                  ctrl_d.stall      = 1'b1;
                  ctrl_d.m_cycle_op = mc_op;
               end else begin
                  ctrl_d            = dec;
                  ctrl_d.m_cycle_op = ctrl_q.m_cycle_op;
               end
            end
         end
         MC_START: begin
            state_d      = MC_WAIT;
            cnt_d        = '0;
            ctrl_d.stall = 1'b1;
         end
         MC_WAIT: begin
            ctrl_d.stall = 1'b1;
            if (!bus_if.m_busy) begin
               state_d          = MC_DONE;
               ctrl_d.stall     = 1'b0;
               ctrl_d.dec_valid = 1'b1;
               ctrl_d.reg_w     = 1'b1;
               ctrl_d.pcs       = (rd_q == 4'hF);
            end else if (cnt_q == CNT_LAST) begin
               state_d          = IDLE;
               ctrl_d.stall     = 1'b0;
               ctrl_d.dec_valid = 1'b1;
               ctrl_d.undef     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus_if.pcs         = ctrl_q.pcs;
   assign bus_if.reg_w       = ctrl_q.reg_w;
   assign bus_if.mem_w       = ctrl_q.mem_w;
   assign bus_if.mem_to_reg  = ctrl_q.mem_to_reg;
   assign bus_if.alu_src     = ctrl_q.alu_src;
   assign bus_if.imm_src     = ctrl_q.imm_src;
   assign bus_if.reg_src     = ctrl_q.reg_src;
   assign bus_if.no_write    = ctrl_q.no_write;
   assign bus_if.alu_control = ctrl_q.alu_control;
   assign bus_if.flag_w      = ctrl_q.flag_w;
   assign bus_if.m_start     = ctrl_q.m_start;
   assign bus_if.m_cycle_op  = ctrl_q.m_cycle_op;
   assign bus_if.stall       = ctrl_q.stall;
   assign bus_if.dec_valid   = ctrl_q.dec_valid;
   assign bus_if.undef       = ctrl_q.undef;
endmodule

// File: tb/tb_decoder_ctrl_fsm.sv
// Self-checking bench for decoder_ctrl_fsm: directed scenarios plus randomized decode against a mnemonic-level model.
module tb_decoder_ctrl_fsm;
   localparam int unsigned T_OUT = 8;

`ifdef DECODER_CTRL_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct packed {
      logic       dec_valid, undef, pcs, reg_w, mem_w, mem_to_reg, alu_src;
      logic [1:0] imm_src, reg_src;
      logic       no_write;
      logic [3:0] alu;
      logic [1:0] flag_w;
      logic       m_start, stall;
      logic [1:0] mc_op;
   } vec_t;

   localparam logic [21:0] M_ALL   = 22'h3FFFFF;
   localparam logic [21:0] M_FULL  = 22'h3FFFFC;
   localparam logic [21:0] M_UNDEF = 22'h3E003C;
   localparam logic [21:0] M_IDLE  = 22'h2E003C;
   localparam logic [21:0] M_MC    = 22'h3F003F;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   decoder_ctrl_fsm_if #(.ALU_W(3)) bus_a ();
   decoder_ctrl_fsm_if #(.ALU_W(2)) bus_b ();

   assign bus_b.instr_valid = bus_a.instr_valid;
   assign bus_b.rd          = bus_a.rd;
   assign bus_b.op          = bus_a.op;
   assign bus_b.funct       = bus_a.funct;
   assign bus_b.m_bits      = bus_a.m_bits;
   assign bus_b.m_busy      = bus_a.m_busy;

   decoder_ctrl_fsm #(.ALU_W(3), .MC_TIMEOUT(T_OUT)) dut_a (.clk_i(clk), .rst_i(rst), .bus_if(bus_a));
   decoder_ctrl_fsm #(.ALU_W(2), .MC_TIMEOUT(64))    dut_b (.clk_i(clk), .rst_i(rst), .bus_if(bus_b));

   function automatic vec_t obs_a();
      return {bus_a.dec_valid, bus_a.undef, bus_a.pcs, bus_a.reg_w, bus_a.mem_w, bus_a.mem_to_reg,
              bus_a.alu_src, bus_a.imm_src, bus_a.reg_src, bus_a.no_write, 4'(bus_a.alu_control),
              bus_a.flag_w, bus_a.m_start, bus_a.stall, bus_a.m_cycle_op};
   endfunction

   function automatic vec_t obs_b();
      return {bus_b.dec_valid, bus_b.undef, bus_b.pcs, bus_b.reg_w, bus_b.mem_w, bus_b.mem_to_reg,
              bus_b.alu_src, bus_b.imm_src, bus_b.reg_src, bus_b.no_write, 4'(bus_b.alu_control),
              bus_b.flag_w, bus_b.m_start, bus_b.stall, bus_b.m_cycle_op};
   endfunction

   function automatic string dp_name(input logic [3:0] cmd);
      case (cmd)
         4'd4:    return "ADD";
         4'd2:    return "SUB";
         4'd10:   return "CMP";
         4'd11:   return "CMN";
         4'd0:    return "AND";
         4'd8:    return "TST";
         4'd12:   return "ORR";
         4'd1:    return "EOR";
         default: return "";
      endcase
   endfunction

   // Expected decode of one instruction for a decoder of the given ALU width.
   function automatic vec_t model(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                                  input logic [3:0] mbits, input int alu_w, output bit mc);
      vec_t  e;
      string nm;
      bit    bad;
      int    code;
      e = '0; bad = 1'b0; code = 0; mc = 1'b0;
      if (op == 2'b00) begin
         if (!funct[5] && mbits == 4'b1001) begin
            if (funct[4:1] == 4'd0 || (funct[4:1] == 4'd1 && DIV_EN)) mc = 1'b1;
            else bad = 1'b1;
         end else begin
            nm = dp_name(funct[4:1]);
            if (nm == "") bad = 1'b1;
            else begin
               if (nm == "ADD" || nm == "CMN")      code = 0;
               else if (nm == "SUB" || nm == "CMP") code = 1;
               else if (nm == "AND" || nm == "TST") code = 2;
               else if (nm == "ORR")                code = 3;
               else                                 code = 4;
               e.no_write = (nm == "CMP" || nm == "CMN" || nm == "TST");
               e.reg_w    = !e.no_write;
               e.alu_src  = funct[5];
               if (funct[0]) e.flag_w = (nm == "AND" || nm == "ORR" || nm == "EOR" || nm == "TST") ? 2'b10 : 2'b11;
            end
         end
      end else if (op == 2'b01) begin
         e.alu_src = 1'b1; e.imm_src = 2'b01; code = funct[3] ? 0 : 1;
         if (funct[0]) begin e.reg_w = 1'b1; e.mem_to_reg = 1'b1; end
         else begin e.mem_w = 1'b1; e.reg_src = 2'b10; end
      end else if (op == 2'b10) begin
         e.pcs = 1'b1; e.alu_src = 1'b1; e.imm_src = 2'b10; e.reg_src = 2'b01;
      end else begin
         bad = 1'b1;
      end
      if (code >= (1 << alu_w)) bad = 1'b1;
      e.alu = 4'(code);
      if (rd == 4'hF && e.reg_w) e.pcs = 1'b1;
      if (bad) begin
         e.undef = 1'b1; e.reg_w = 1'b0; e.mem_w = 1'b0; e.pcs = 1'b0; e.flag_w = 2'b00;
      end
      e.dec_valid = !mc;
      return e;
   endfunction

   task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                        input logic [3:0] mb, input bit busy);
      bus_a.instr_valid = v;
      bus_a.op          = op;
      bus_a.funct       = f;
      bus_a.rd          = rd;
      bus_a.m_bits      = mb;
      bus_a.m_busy      = busy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t o;
      rst = 1'b1;
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      #1;
      vectors++; o = obs_a();
      if ((o & M_ALL) !== 22'd0) begin miscompares++; $display("FAIL reset_a: got %h want %h", o & M_ALL, 22'd0); end
      vectors++; o = obs_b();
      if ((o & M_ALL) !== 22'd0) begin miscompares++; $display("FAIL reset_b: got %h want %h", o & M_ALL, 22'd0); end
      tick(); tick();
      rst = 1'b0;
      tick();
      vectors++; o = obs_a();
      if ((o & M_IDLE) !== 22'd0) begin miscompares++; $display("FAIL post_reset_idle: got %h want %h", o & M_IDLE, 22'd0); end
   endtask

   task automatic test_dp_sub_pc();
      vec_t o, e;
      drive(1'b1, 2'b00, 6'b100101, 4'hF, 4'd0, 1'b0);
      tick();
      e = '0; e.dec_valid = 1; e.pcs = 1; e.reg_w = 1; e.alu_src = 1; e.alu = 4'd1; e.flag_w = 2'b11;
      vectors++; o = obs_a();
      if ((o & M_FULL) !== (e & M_FULL)) begin miscompares++; $display("FAIL dp_sub_pc_a: got %h want %h", o & M_FULL, e & M_FULL); end
      vectors++; o = obs_b();
      if ((o & M_FULL) !== (e & M_FULL)) begin miscompares++; $display("FAIL dp_sub_pc_b: got %h want %h", o & M_FULL, e & M_FULL); end
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      tick();
   endtask

   task automatic test_back_to_back();
      vec_t o, e;
      drive(1'b1, 2'b01, 6'b011001, 4'd3, 4'd0, 1'b0);
      tick();
      drive(1'b1, 2'b01, 6'b010000, 4'd3, 4'd0, 1'b0);
      e = '0; e.dec_valid = 1; e.reg_w = 1; e.mem_to_reg = 1; e.alu_src = 1; e.imm_src = 2'b01; e.alu = 4'd0;
      vectors++; o = obs_a();
      if ((o & M_FULL) !== (e & M_FULL)) begin miscompares++; $display("FAIL ldr: got %h want %h", o & M_FULL, e & M_FULL); end
      tick();
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      e = '0; e.dec_valid = 1; e.mem_w = 1; e.reg_src = 2'b10; e.alu_src = 1; e.imm_src = 2'b01; e.alu = 4'd1;
      vectors++; o = obs_a();
      if ((o & M_FULL) !== (e & M_FULL)) begin miscompares++; $display("FAIL str: got %h want %h", o & M_FULL, e & M_FULL); end
      tick();
      vectors++; o = obs_a();
      if ((o & M_IDLE) !== 22'd0) begin miscompares++; $display("FAIL idle_after_str: got %h want %h", o & M_IDLE, 22'd0); end
   endtask

   task automatic test_undef();
      vec_t o, e, u;
      u = '0; u.dec_valid = 1; u.undef = 1;
      drive(1'b1, 2'b00, 6'b000010, 4'd1, 4'd0, 1'b0);
      tick();
      e = '0; e.dec_valid = 1; e.reg_w = 1; e.alu = 4'd4;
      vectors++; o = obs_a();
      if ((o & M_FULL) !== (e & M_FULL)) begin miscompares++; $display("FAIL eor_w3: got %h want %h", o & M_FULL, e & M_FULL); end
      vectors++; o = obs_b();
      if ((o & M_UNDEF) !== (u & M_UNDEF)) begin miscompares++; $display("FAIL eor_w2_undef: got %h want %h", o & M_UNDEF, u & M_UNDEF); end
      drive(1'b1, 2'b11, 6'b101011, 4'hF, 4'd0, 1'b0);
      tick();
      vectors++; o = obs_a();
      if ((o & M_UNDEF) !== (u & M_UNDEF)) begin miscompares++; $display("FAIL op11_undef: got %h want %h", o & M_UNDEF, u & M_UNDEF); end
      if (!DIV_EN) begin
         drive(1'b1, 2'b00, 6'b000010, 4'd2, 4'b1001, 1'b0);
         tick();
         vectors++; o = obs_a();
         if ((o & M_UNDEF) !== (u & M_UNDEF)) begin miscompares++; $display("FAIL div_disabled: got %h want %h", o & M_UNDEF, u & M_UNDEF); end
      end
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      tick();
   endtask

   task automatic test_random(input int n);
      vec_t       o, ea, eb;
      logic [21:0] ma, mbm;
      bit         mc, v;
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd, mb, cmd;
      bit [3:0]   cmds [8];
      cmds = '{4'd4, 4'd2, 4'd10, 4'd11, 4'd0, 4'd8, 4'd12, 4'd1};
      for (int i = 0; i < n; i++) begin
         do begin
            op  = 2'($urandom_range(0, 3));
            cmd = ($urandom % 5 == 0) ? 4'($urandom) : cmds[$urandom % 8];
            f   = (op == 2'b00) ? {1'($urandom), cmd, 1'($urandom)} : 6'($urandom);
            rd  = ($urandom % 4 == 0) ? 4'hF : 4'($urandom);
            mb  = ($urandom % 3 == 0) ? 4'b1001 : 4'($urandom);
            ea  = model(op, f, rd, mb, 3, mc);
         end while (mc);
         eb = model(op, f, rd, mb, 2, mc);
         v  = ($urandom % 4 != 0);
         drive(v, op, f, rd, mb, 1'($urandom));
         tick();
         if (!v) begin ea = '0; eb = '0; end
         ma  = !v ? M_IDLE : (ea.undef ? M_UNDEF : M_FULL);
         mbm = !v ? M_IDLE : (eb.undef ? M_UNDEF : M_FULL);
         vectors++; o = obs_a();
         if ((o & ma) !== (ea & ma)) begin
            miscompares++; $display("FAIL rand_a op=%b f=%b rd=%h mb=%b: got %h want %h", op, f, rd, mb, o & ma, ea & ma);
         end
         vectors++; o = obs_b();
         if ((o & mbm) !== (eb & mbm)) begin
            miscompares++; $display("FAIL rand_b op=%b f=%b rd=%h mb=%b: got %h want %h", op, f, rd, mb, o & mbm, eb & mbm);
         end
      end
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      tick();
   endtask

   // Multi-cycle op with m_busy high for n wait samples; outcome is done (n < T_OUT) or timeout abort.
   task automatic test_multicycle(input bit div, input logic [3:0] rd, input int n);
      vec_t o, e;
      logic [21:0] m;
      int   k, endc;
      bit   abort;
      k     = (n < int'(T_OUT)) ? n : int'(T_OUT) - 1;
      abort = (n >= int'(T_OUT));
      endc  = 2 + k;
      drive(1'b1, 2'b00, {1'b0, div ? 4'b0001 : 4'b0000, 1'b0}, rd, 4'b1001, 1'b1);
      for (int c = 0; c <= endc + 1; c++) begin
         tick();
         e = '0; e.mc_op = div ? 2'b01 : 2'b00; m = M_MC;
         if (c == 0) begin
            e.m_start = 1; e.stall = 1;
         end else if (c < endc) begin
            e.stall = 1;
         end else if (c == endc) begin
            e.dec_valid = 1;
            if (abort) e.undef = 1;
            else begin e.reg_w = 1; e.pcs = (rd == 4'hF); end
         end else begin
            e = '0; m = M_IDLE;
         end
         vectors++; o = obs_a();
         if ((o & m) !== (e & m)) begin
            miscompares++; $display("FAIL mc div=%0d n=%0d cyc=%0d: got %h want %h", div, n, c, o & m, e & m);
         end
         if (c + 1 <= endc) drive(1'($urandom), 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), (c - 1 < n));
         else               drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid_wait();
      vec_t o;
      drive(1'b1, 2'b00, 6'b000000, 4'd5, 4'b1001, 1'b1);
      tick();
      drive(1'b0, 2'b00, 6'b000000, 4'd5, 4'b1001, 1'b1);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      vectors++; o = obs_a();
      if ((o & M_ALL) !== 22'd0) begin miscompares++; $display("FAIL rst_wait_a: got %h want %h", o & M_ALL, 22'd0); end
      vectors++; o = obs_b();
      if ((o & M_ALL) !== 22'd0) begin miscompares++; $display("FAIL rst_wait_b: got %h want %h", o & M_ALL, 22'd0); end
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++; o = obs_a();
         if ((o & M_IDLE) !== 22'd0) begin miscompares++; $display("FAIL rst_release_%0d: got %h want %h", i, o & M_IDLE, 22'd0); end
      end
      drive(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_dp_sub_pc();
      test_back_to_back();
      test_undef();
      test_random(300);
      test_multicycle(1'b0, 4'd3, 5);
      test_multicycle(1'b0, 4'hF, 0);
      for (int i = 0; i < 4; i++) test_multicycle(1'b0, 4'($urandom), int'($urandom_range(0, 6)));
      test_multicycle(1'b0, 4'd2, 12);
      if (DIV_EN) begin
         test_multicycle(1'b1, 4'd4, 20);
         test_multicycle(1'b1, 4'd6, 3);
      end
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/decoder_ctrl_fsm.md
DECODER_CTRL_FSM -- requirements
Module: decoder_ctrl_fsm

Interface
REQ-001 Parameter ALU_W, default 3, meaning ALUControl width; legal values 2..4.
REQ-002 Parameter MC_TIMEOUT, default 64, meaning maximum MC_WAIT cycles before abort; legal values 2..255.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 InstrValid  input  1  Rd/Op/Funct/MBits hold a valid instruction this cycle.
REQ-006 Rd  input  4  destination register field (Instr[15:12]).
REQ-007 Op  input  2  opcode field (Instr[27:26]).
REQ-008 Funct  input  6  function field (Instr[25:20]).
REQ-009 MBits  input  4  Instr[7:4], used for multiply/divide detection.
REQ-010 MBusy  input  1  the multi-cycle unit is busy.
REQ-011 Control outputs, all registered: PCS 1, RegW 1, MemW 1, MemtoReg 1, ALUSrc 1, ImmSrc 2, RegSrc 2, NoWrite 1, ALUControl ALU_W, FlagW 2.
REQ-012 MStart  output  1  one-cycle start pulse to the multi-cycle unit.
REQ-013 MCycleOp  output  2  multi-cycle operation: 00 MUL, 01 DIV.
REQ-014 Stall  output  1  the decoder cannot accept a new instruction.
REQ-015 DecValid  output  1  control outputs are valid this cycle.
REQ-016 Undef  output  1  the current instruction is undefined, unsupported or aborted.

Function
REQ-017 The FSM SHALL have the states IDLE, MC_START, MC_WAIT and MC_DONE.
REQ-018 IDLE behaviour SHALL be as follows.
- Condition: InstrValid=1 with a single-cycle decode.
- Response: outputs are registered and DecValid=1 on the next cycle (latency 1).
- Back-to-back instructions are accepted every cycle.
REQ-019 The DP decode (Op=00) SHALL use cmd=Funct[4:1].
- ALUControl: ADD/CMN 0, SUB/CMP 1, AND/TST 2, ORR 3, EOR 4.
- NoWrite=1 for CMP, CMN and TST.
- RegW=!NoWrite.
- ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00.
REQ-020 FlagW SHALL be 00 when Funct[0]=0, 11 for ADD/SUB/CMP/CMN, and 10 for AND/ORR/EOR/TST.
REQ-021 The memory decode (Op=01) SHALL set ALUSrc=1, ImmSrc=01 and ALUControl=ADD when Funct[3]=1, SUB otherwise.
- LDR (Funct[0]=1): RegW=1, MemtoReg=1, RegSrc=00.
- STR (Funct[0]=0): MemW=1, RegSrc=10.
REQ-022 The branch decode (Op=10) SHALL set PCS=1, ALUSrc=1, ImmSrc=10, RegSrc=01 and ALUControl=ADD, with RegW=0.
REQ-023 PCS SHALL equal (Rd==4'hF AND RegW) OR branch.
REQ-024 Undef SHALL assert on any of the following, and then RegW, MemW, PCS, FlagW and MStart are forced to 0:
- Op=11;
- an unlisted DP cmd;
- an ALUControl code of 2^ALU_W or more (for example EOR when ALU_W=2).
REQ-025 Multi-cycle detect SHALL be Op=00, Funct[5]=0 and MBits=1001.
- Funct[4:1]=0000 is MUL.
- Funct[4:1]=0001 is DIV.
REQ-026 IDLE with a multi-cycle instruction SHALL go to MC_START: MStart=1 for exactly one cycle, MCycleOp latched, Stall=1.
REQ-027 MC_START SHALL go to MC_WAIT.
- Stall stays 1.
- A wait counter clears to 0, then increments by 1 each cycle.
REQ-028 MC_WAIT with MBusy=0 SHALL go to MC_DONE.
REQ-029 In MC_DONE the block SHALL drive DecValid=1, RegW=1, MemtoReg=0, FlagW=00 and Stall=0, then return to IDLE.
REQ-030 MC_WAIT with the counter equal to MC_TIMEOUT-1 while MBusy=1 SHALL do the following:
- assert DecValid=1 and Undef=1 for one cycle;
- drive all writes 0;
- return to IDLE.
REQ-031 While Stall=1, InstrValid and the instruction fields SHALL be ignored; the source holds them.
REQ-032 When InstrValid=0 in IDLE, DecValid, RegW, MemW, PCS, FlagW and MStart SHALL be driven 0 on the next cycle.

Reset
REQ-033 RESET=1 SHALL immediately do the following:
- force state IDLE and the counter to 0;
- drive every output to 0, including ALUControl, ImmSrc, RegSrc and MCycleOp.
REQ-034 RESET asserted during MC_START or MC_WAIT SHALL abort the operation; no MStart and no DecValid follow the reset release.

Configuration
REQ-035 The macro DECODER_CTRL_DIV_EN SHALL control DIV support.
- Defined: DIV is decoded per REQ-025.
- Undefined: the DIV pattern yields Undef=1, with no MStart and no stall.

Verification
REQ-036 Rd=F, Op=00, Funct=100101, InstrValid=1 -> next cycle: PCS=1, RegW=1, ALUSrc=1, ImmSrc=00, NoWrite=0, ALUControl=1, FlagW=11, DecValid=1.
REQ-037 Op=01, Funct=011001 (LDR, U=1) -> RegW=1, MemtoReg=1, ALUControl=0; then Funct=010000 (STR, U=0) the next cycle -> MemW=1, RegSrc=10, ALUControl=1.
REQ-038 MUL (Op=00, Funct=000000, MBits=1001) with MBusy high for 5 cycles -> MStart pulses once, MCycleOp=00, Stall=1 until MC_DONE, then DecValid=1 and RegW=1.
REQ-039 DIV with MBusy held high and MC_TIMEOUT=8 -> Undef=1 and DecValid=1 in the cycle after the counter reaches 7, writes 0, and the FSM is back in IDLE.
REQ-040 ALU_W=2 with EOR (Funct=000010), and Op=11 -> Undef=1, RegW=0; DIV with DECODER_CTRL_DIV_EN undefined -> Undef=1, MStart=0.
REQ-041 RESET asserted during MC_WAIT -> all outputs 0 immediately; after release, no DecValid until a new InstrValid.
